// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file writeback arbiter with per-unit result FIFOs
// Round-robin by default; define WB_FIXED_PRIO_EN for fixed MUL > MEM > AM priority.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        am_wb_oper,
  input  logic [4:0]  am_wb_regdest,
  input  logic        am_wb_writereg,
  input  logic [31:0] am_wb_wbvalue,
  input  logic        mem_wb_oper,
  input  logic [4:0]  mem_wb_regdest,
  input  logic        mem_wb_writereg,
  input  logic [31:0] mem_wb_wbvalue,
  input  logic        mul_wb_oper,
  input  logic [4:0]  mul_wb_regdest,
  input  logic        mul_wb_writereg,
  input  logic [31:0] mul_wb_wbvalue,
  output logic [2:0]  wb_full,
  output logic        wb_reg_en,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic [2:0]  wb_retire,
  output logic        wb_overflow
);

  // Entry layout: {regdest, writereg, wbvalue}
  localparam int EW       = 38;
  localparam int WR_BIT   = 32;
  localparam int RD_LO    = 33;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [2:0]    oper;
  logic [EW-1:0] entry_in [3];
  logic [EW-1:0] fifo_mem [3][DEPTH];
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [AW:0]   count [3];
  logic [AW:0]   count_next [3];
  logic [2:0]    nonempty;
  logic [2:0]    full_now;
  logic [2:0]    full_next;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic [2:0]    grant;
  logic [1:0]    grant_idx;
  logic [EW-1:0] head;
  logic          drop;

  assign oper        = {mul_wb_oper, mem_wb_oper, am_wb_oper};
  assign entry_in[0] = {am_wb_regdest, am_wb_writereg, am_wb_wbvalue};
  assign entry_in[1] = {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue};
  assign entry_in[2] = {mul_wb_regdest, mul_wb_writereg, mul_wb_wbvalue};

  always_comb begin
    nonempty = '0;
    full_now = '0;
    for (int u = 0; u < 3; u++) begin
      nonempty[u] = (count[u] != '0);
      full_now[u] = (count[u] == FULL_CNT);
    end
  end

`ifdef WB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    if (nonempty[2])      grant = 3'b100;
    else if (nonempty[1]) grant = 3'b010;
    else if (nonempty[0]) grant = 3'b001;
  end
`else
  logic [1:0] rr_ptr;
  logic [1:0] cand;
  logic       found;

  function automatic logic [1:0] next_unit(input logic [1:0] u);
    return (u == 2'd2) ? 2'd0 : u + 2'd1;
  endfunction

  // Search starts at rr_ptr and wraps AM -> MEM -> MUL.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      if (!found && nonempty[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
      cand = next_unit(cand);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (grant != 3'b000) begin
      rr_ptr <= next_unit(grant_idx);
    end
  end
`endif

  always_comb begin
    grant_idx = 2'd0;
    if (grant[1]) grant_idx = 2'd1;
    if (grant[2]) grant_idx = 2'd2;
  end

  assign pop  = grant;
  assign head = fifo_mem[grant_idx][rd_ptr[grant_idx]];

  // A full FIFO still accepts a push when it pops in the same cycle.
  always_comb begin
    push      = '0;
    full_next = '0;
    for (int u = 0; u < 3; u++) begin
      push[u]       = oper[u] && (!full_now[u] || pop[u]);
      count_next[u] = count[u];
      if (push[u] && !pop[u])
        count_next[u] = count[u] + (AW+1)'(1);
      else if (pop[u] && !push[u])
        count_next[u] = count[u] - (AW+1)'(1);
      full_next[u] = (count_next[u] == FULL_CNT);
    end
  end

  assign drop = |(oper & full_now & ~pop);

  always_ff @(posedge clock) begin
    for (int u = 0; u < 3; u++) begin
      if (push[u]) fifo_mem[u][wr_ptr[u]] <= entry_in[u];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < 3; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        count[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (push[u]) wr_ptr[u] <= wr_ptr[u] + AW'(1);
        if (pop[u])  rd_ptr[u] <= rd_ptr[u] + AW'(1);
        count[u] <= count_next[u];
      end
    end
  end

  // Address and data hold their last committed values on idle cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_full     <= '0;
      wb_reg_en   <= 1'b0;
      wb_reg_addr <= '0;
      wb_reg_data <= '0;
      wb_retire   <= '0;
      wb_overflow <= 1'b0;
    end else begin
      wb_full     <= full_next;
      wb_overflow <= wb_overflow | drop;
      wb_retire   <= grant;
      wb_reg_en   <= 1'b0;
      if (grant != 3'b000) begin
        wb_reg_en   <= head[WR_BIT] && (head[EW-1:RD_LO] != 5'd0);
        wb_reg_addr <= head[EW-1:RD_LO];
        wb_reg_data <= head[31:0];
      end
    end
  end

endmodule
